// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the in-order RISC-V pipeline.
//
// Holds the program counter. Issues sequential word fetches over a
// valid/ready request channel whose responses return in order. Buffers the
// returned instructions with their PCs in a DEPTH-entry FIFO and presents
// them to decode through a valid/ready handshake. A redirect discards every
// buffered and in-flight fetch. Responses that were still outstanding when
// the redirect happened are counted and dropped when they arrive.
//
// Parameters
//   RESET_PC        PC of the first fetch after reset
//   DEPTH           buffer entries; also the maximum number of allocated
//                   fetches (power of two, >= 2)
// Ports
//   clk, reset      clock and synchronous active-high reset
//   redirect_valid  taken branch/jump; overrides everything else
//   redirect_pc     new fetch target, bits [1:0] ignored
//   imem_req_*      fetch request channel (valid/ready, word address)
//   imem_rsp_*      in-order fetch responses (no backpressure)
//   if_valid/ready  handshake towards decode
//   if_instruction  instruction word at the head of the buffer
//   if_pc           PC of if_instruction
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  // drop_cnt gets two bits of headroom beyond DEPTH: back-to-back redirects
  // against a slow memory can stack up more stale responses than one FIFO's
  // worth before the first of them returns.
  localparam int unsigned DW = PW + 3;

  logic [31:0]    pc;
  logic [31:0]    ent_pc    [DEPTH];
  logic [31:0]    ent_instr [DEPTH];
  logic [DEPTH-1:0] ent_filled;

  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [PW-1:0]  fill;
  logic [CW-1:0]  count;     // allocated entries
  logic [CW-1:0]  pend;      // allocated but not yet filled
  logic [DW-1:0]  drop_cnt;  // stale responses still to discard

  logic deq;
  logic acc;
  logic rsp_drop;
  logic rsp_fill;
  logic unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  assign if_valid       = !reset && (count != '0) && ent_filled[head];
  assign deq            = if_valid && if_ready;
  assign if_instruction = ent_instr[head];
  assign if_pc          = ent_pc[head];

  // A slot freed by this cycle's deq can be reused by this cycle's request.
  assign imem_req_valid = !reset && ((count - CW'(deq)) < CW'(DEPTH));
  assign imem_req_addr  = pc;
  assign acc            = imem_req_valid && imem_req_ready;

  // Responses are in order, so stale ones always arrive before fresh ones.
  // A response with nothing to drop and nothing to fill is ignored.
  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && (pend != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      fill       <= '0;
      count      <= '0;
      pend       <= '0;
      drop_cnt   <= '0;
      ent_filled <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_pc[i]    <= '0;
        ent_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc         <= {redirect_pc[31:2], 2'b00};
      head       <= '0;
      tail       <= '0;
      fill       <= '0;
      count      <= '0;
      pend       <= '0;
      ent_filled <= '0;
      // Everything still owed by memory becomes stale: unfilled entries plus
      // a request accepted now, less the response consumed this cycle
      // (whether it was filling or already being dropped).
      drop_cnt   <= drop_cnt + DW'(pend) + DW'(acc) - DW'(rsp_drop || rsp_fill);
    end else begin
      if (acc) begin
        ent_pc[tail]     <= pc;
        ent_filled[tail] <= 1'b0;
        tail             <= tail + PW'(1);
        pc               <= pc + 32'd4;
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - DW'(1);
      end
      // fill never equals tail while an allocation happens: that would need
      // every entry unfilled, which blocks deq and therefore the request.
      if (rsp_fill) begin
        ent_instr[fill]  <= imem_rsp_data;
        ent_filled[fill] <= 1'b1;
        fill             <= fill + PW'(1);
      end
      if (deq) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(acc) - CW'(deq);
      pend  <= pend + CW'(acc) - CW'(rsp_fill);
    end
  end

endmodule
